sensor_init_sequencer: RTL and testbench
========================================

Name: sensor_init_sequencer

Overview:
Walks a fixed table of (register, data) pairs and issues each one as a single-register I2C write through the downstream register-write block. That block takes start, dev/reg address and data, and returns done or message_failure.
Handles retries, inter-write settle gaps and in-table delay entries. Reports overall success or failure, plus the failing table index, to the sensor top level.

Parameters:
NUM_ENTRIES, 32, number of table words used (1..256)
DEV_ADDR, 7'h21, 7-bit I2C device address driven on every write
MAX_RETRIES, 3, extra attempts per entry after first failure (0..15)
SETTLE_CYCLES, 64, idle clk cycles between end of one write and next wr_start (>=2)
WATCHDOG_CYCLES, 2000000, clk cycles allowed from wr_start to completion before counting as failure
DELAY_SHIFT, 10, delay entry unit = 2^DELAY_SHIFT clk cycles

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
go  in  1  begin sequence; sampled only in IDLE
busy  out  1  high from accepting go until DONE/ERROR entered
init_done  out  1  sticky; table completed without error
init_error  out  1  sticky; an entry exhausted retries
error_index  out  8  table index of failing entry (valid with init_error)
wr_dev_address  out  7  to writer dev_address
wr_reg_address  out  8  to writer reg_address
wr_data  out  8  to writer data
wr_start  out  1  one-cycle start pulse to writer
wr_done  in  1  writer done
wr_failure  in  1  writer message_failure

Behaviour:
- Reset: all outputs 0 except wr_dev_address = DEV_ADDR. State IDLE, index 0, counters cleared. Reset mid-sequence aborts immediately; no further wr_start pulses.
- Table word is 16 bits {reg[15:8], data[7:0]}. reg == 8'hFF marks a delay entry: wait (data+1)<<DELAY_SHIFT cycles, no I2C traffic.
- States:
  - IDLE: on go -> LOAD; busy=1; index=0; init_done and init_error cleared.
  - LOAD: latch ROM word at index; ROM has one-cycle read latency. Delay entry -> DELAY; else -> ISSUE.
  - ISSUE: wr_reg_address and wr_data already stable from LOAD. Assert wr_start for exactly 1 cycle. Clear watchdog -> WAIT.
  - WAIT: completion is the first cycle with wr_done=1 or wr_failure=1, or watchdog expiry.
    - Failure: wr_failure=1 (takes priority when wr_done is coincident) or watchdog expiry. If retry_cnt < MAX_RETRIES: retry_cnt++, -> SETTLE, then re-ISSUE the same entry. Else -> ERROR.
    - Success: wr_done=1 alone. retry_cnt=0 -> SETTLE, then NEXT.
  - SETTLE: count SETTLE_CYCLES. wr_start held 0. Lets the writer return to its idle state before the next start.
  - DELAY: count down; at zero -> NEXT.
  - NEXT: if index == NUM_ENTRIES-1 -> DONE; else index++ -> LOAD.
  - DONE: init_done=1, busy=0 -> IDLE; init_done stays high until next accepted go.
  - ERROR: init_error=1, error_index=index, busy=0 -> IDLE.
- go while busy is ignored. wr_done/wr_failure outside WAIT are ignored.
- wr_reg_address and wr_data hold their last values when not in use; there is no tristating.
- Counter widths: clog2 of the respective max values. Watchdog saturates, no wrap.
- Latency, success path with no retries: go -> first wr_start = 3 cycles (IDLE, LOAD, ISSUE).

Decomposition:
- Shared package sensor_pkg:
  - state enum
  - DELAY_MARKER = 8'hFF
  - table word field positions
- Sub-module sensor_config_rom: synchronous 256x16 ROM holding the init table, index in, word out, 1-cycle latency.
- Sequencer FSM and counters stay in the top module.

Test Plan:
- 3-entry table {0x12,0x80},{0x11,0x01},{0x6B,0x4A}; writer model asserts wr_done 20 cycles after each start -> three wr_start pulses with matching reg/data, gaps >= SETTLE_CYCLES; init_done=1; busy falls after DONE.
- Entry 1 fails twice (wr_failure pulse), then succeeds, MAX_RETRIES=3 -> entry 1 issued 3 times; init_done=1; init_error=0.
- Entry 2 fails 4 times, MAX_RETRIES=3 -> init_error=1, error_index=2, no further wr_start; init_done=0.
- Delay entry {0xFF,0x03} with DELAY_SHIFT=4 between two writes -> gap of 64 cycles plus settle with no wr_start.
- Writer never responds, WATCHDOG_CYCLES=100, MAX_RETRIES=0 -> ERROR 100 cycles after start, error_index=0.
- reset asserted in WAIT of entry 1; wr_done=1 and wr_failure=1 arriving together -> failure path taken; after reset all outputs at reset values, no wr_start until a new go.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor init sequencer and its config ROM.
package sensor_pkg;

  // Sequencer states.
  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_SETTLE,
    S_DELAY,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_e;

  // A register field equal to this value turns the entry into a wait, not a write.
  localparam logic [7:0] DELAY_MARKER = 8'hFF;

  // Table word layout: {reg[15:8], data[7:0]}.
  localparam int REG_MSB  = 15;
  localparam int REG_LSB  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  typedef logic [255:0][15:0] table_t;

  function automatic logic [7:0] word_reg(input logic [15:0] w);
    return w[REG_MSB:REG_LSB];
  endfunction

  function automatic logic [7:0] word_data(input logic [15:0] w);
    return w[DATA_MSB:DATA_LSB];
  endfunction

  // Default bring-up table; unused slots are minimum-length delays so a
  // longer NUM_ENTRIES never writes stray registers.
  function automatic table_t default_table();
    table_t t;
    for (int i = 0; i < 256; i++) t[i] = {DELAY_MARKER, 8'h00};
    t[0] = 16'h1280;
    t[1] = 16'h1101;
    t[2] = 16'h6B4A;
    return t;
  endfunction

endpackage

// File: rtl/sensor_init_sequencer_if.sv
// Handshake between the init sequencer and the single-register I2C writer.
interface sensor_init_sequencer_if;
  logic [6:0] wr_dev_address;
  logic [7:0] wr_reg_address;
  logic [7:0] wr_data;
  logic       wr_start;
  logic       wr_done;
  logic       wr_failure;

  modport master (
    output wr_dev_address, wr_reg_address, wr_data, wr_start,
    input  wr_done, wr_failure
  );

  modport slave (
    input  wr_dev_address, wr_reg_address, wr_data, wr_start,
    output wr_done, wr_failure
  );
endinterface

// File: rtl/sensor_config_rom.sv
// Synchronous 256x16 table of (register, data) words, one-cycle read latency.
module sensor_config_rom
  import sensor_pkg::*;
#(
  parameter table_t TABLE = default_table()
) (
  input  logic        clk,
  input  logic [7:0]  addr_i,
  output logic [15:0] word_o
);

  logic [15:0] word_q;

  // Registered read of the addressed word.
  // NOTE: the read register has no reset; its contents are constant and are
  // only consumed in LOAD, one cycle after a valid address has been presented.
  always_ff @(posedge clk) begin
    word_q <= TABLE[addr_i];
  end

  assign word_o = word_q;

endmodule

// File: rtl/sensor_init_sequencer.sv
// Walks the config table, issuing one I2C register write per entry with
// retries, settle gaps and in-table delays; reports done/error upward.
module sensor_init_sequencer
  import sensor_pkg::*;
#(
  parameter int         NUM_ENTRIES     = 32,
  parameter logic [6:0] DEV_ADDR        = 7'h21,
  parameter int         MAX_RETRIES     = 3,
  parameter int         SETTLE_CYCLES   = 64,
  parameter int         WATCHDOG_CYCLES = 2000000,
  parameter int         DELAY_SHIFT     = 10,
  parameter table_t     INIT_TABLE      = default_table()
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  output logic       busy,
  output logic       init_done,
  output logic       init_error,
  output logic [7:0] error_index,
  sensor_init_sequencer_if.master wr
);

  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = 8 + DELAY_SHIFT;

  localparam logic [RW-1:0] MAX_R       = RW'(MAX_RETRIES);
  localparam logic [WW-1:0] WDOG_LIMIT  = WW'(WATCHDOG_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    LAST_INDEX  = 8'(NUM_ENTRIES - 1);
  // Low bits of a delay count: (data+1)<<SHIFT cycles means loading (data<<SHIFT)+fill.
  localparam logic [DW-1:0] DELAY_FILL  = DW'((1 << DELAY_SHIFT) - 1);

  state_e        state_q, state_d;
  logic [7:0]    index_q, index_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [DW-1:0] delay_q, delay_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [7:0]    err_idx_q, err_idx_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    data_q, data_d;
  logic          start;
  logic [15:0]   rom_word;

  // The ROM is addressed with the next index so the word is ready during LOAD.
  sensor_config_rom #(.TABLE(INIT_TABLE)) u_rom (
    .clk    (clk),
    .addr_i (index_d),
    .word_o (rom_word)
  );

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case statement leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    index_d   = index_q;
    retry_d   = retry_q;
    wdog_d    = wdog_q;
    settle_d  = settle_q;
    delay_d   = delay_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    reg_d     = reg_q;
    data_d    = data_q;
    start     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
          index_d = 8'd0;
          retry_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (word_reg(rom_word) == DELAY_MARKER) begin
          delay_d = (DW'(word_data(rom_word)) << DELAY_SHIFT) | DELAY_FILL;
          state_d = S_DELAY;
        end else begin
          reg_d   = word_reg(rom_word);
          data_d  = word_data(rom_word);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start   = 1'b1;
        wdog_d  = WW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Failure (or a silent writer) wins over a coincident done.
        if (wr.wr_failure || (wdog_q >= WDOG_LIMIT)) begin
          if (retry_q < MAX_R) begin
            retry_d  = retry_q + RW'(1);
            settle_d = '0;
            state_d  = S_SETTLE;
          end else begin
            busy_d    = 1'b0;
            error_d   = 1'b1;
            err_idx_d = index_q;
            state_d   = S_ERROR;
          end
        end else if (wr.wr_done) begin
          retry_d  = '0;
          settle_d = '0;
          state_d  = S_SETTLE;
        end else if (wdog_q < WDOG_LIMIT) begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      S_SETTLE: begin
        // A nonzero retry count means the same entry must be re-issued.
        if (settle_q == SETTLE_LAST) begin
          state_d = (retry_q != '0) ? S_ISSUE : S_NEXT;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_DELAY: begin
        if (delay_q == '0) state_d = S_NEXT;
        else               delay_d = delay_q - DW'(1);
      end
      S_NEXT: begin
        if (index_q == LAST_INDEX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          index_d = index_q + 8'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      retry_q   <= '0;
      wdog_q    <= '0;
      settle_q  <= '0;
      delay_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
      reg_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      retry_q   <= retry_d;
      wdog_q    <= wdog_d;
      settle_q  <= settle_d;
      delay_q   <= delay_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
    end
  end

  assign busy              = busy_q;
  assign init_done         = done_q;
  assign init_error        = error_q;
  assign error_index       = err_idx_q;
  assign wr.wr_dev_address = DEV_ADDR;
  assign wr.wr_reg_address = reg_q;
  assign wr.wr_data        = data_q;
  assign wr.wr_start       = start;

endmodule

// File: tb/tb_sensor_init_sequencer.sv
// Scoreboard bench: a reference plan of expected writes and writer responses is
// queued per run; a monitor checks each wr_start against it, a writer model
// answers from it.
module tb_sensor_init_sequencer;
  import sensor_pkg::*;

  localparam int         NUM    = 4;
  localparam int         MAXR   = 3;
  localparam int         SETTLE = 8;
  localparam int         WDOG   = 100;
  localparam int         DSHIFT = 4;
  localparam logic [6:0] DEV    = 7'h21;

  function automatic table_t tb_table();
    table_t t;
    t    = '0;
    t[0] = 16'h1280;
    t[1] = 16'h1101;
    t[2] = 16'hFF03;   // delay (3+1)<<4 = 64 cycles
    t[3] = 16'h6B4A;
    return t;
  endfunction
  localparam table_t TB_TABLE = tb_table();

  typedef enum {R_DONE, R_FAIL, R_BOTH, R_NONE} resp_e;
  typedef struct { resp_e kind; int delay; } resp_t;
  typedef struct { logic [22:0] txn; int min_gap; } exp_t;

  logic       clk, reset, go;
  logic       busy, init_done, init_error;
  logic [7:0] error_index;
  sensor_init_sequencer_if wr_if ();

  sensor_init_sequencer #(
    .NUM_ENTRIES(NUM), .DEV_ADDR(DEV), .MAX_RETRIES(MAXR),
    .SETTLE_CYCLES(SETTLE), .WATCHDOG_CYCLES(WDOG), .DELAY_SHIFT(DSHIFT),
    .INIT_TABLE(TB_TABLE)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .busy(busy),
    .init_done(init_done), .init_error(init_error),
    .error_index(error_index), .wr(wr_if)
  );

  exp_t  exp_q[$];
  resp_t resp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_comp = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every wr_start must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wr_if.wr_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr_start: got reg %0h expected none (cycle %0d)",
                   wr_if.wr_reg_address, cyc);
        end else begin
          e = exp_q.pop_front();
          check("wr_txn", {wr_if.wr_dev_address, wr_if.wr_reg_address, wr_if.wr_data}, e.txn);
          if (e.min_gap > 0) check("settle_gap", 32'(cyc - last_comp >= e.min_gap), 32'd1);
        end
      end
    end
  end

  // Writer model: answers each start according to the planned response.
  initial begin
    resp_t r;
    wr_if.wr_done    = 1'b0;
    wr_if.wr_failure = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_if.wr_start === 1'b1 && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        if (r.kind == R_NONE) begin
          last_comp = cyc + WDOG;
        end else begin
          repeat (r.delay) @(negedge clk);
          wr_if.wr_done    = (r.kind != R_FAIL);
          wr_if.wr_failure = (r.kind != R_DONE);
          last_comp = cyc;
          @(negedge clk);
          wr_if.wr_done    = 1'b0;
          wr_if.wr_failure = 1'b0;
        end
      end
    end
  end

  // mode 0: no failures; 1: random; 2: directed retries then error on entry 1.
  function automatic int pick_fails(input int mode, input int i);
    int r;
    if (mode == 0) return 0;
    if (mode == 2) return (i == 0) ? 2 : MAXR + 1;
    r = $urandom_range(0, 9);
    if (r < 6) return 0;
    if (r < 8) return $urandom_range(1, MAXR);
    return MAXR + 1;
  endfunction

  function automatic resp_e pick_kind(input int mode, input int i, input int a);
    int r;
    if (mode == 2) begin
      if (i == 0) return (a == 0) ? R_BOTH : R_FAIL;
      return (a == 0) ? R_NONE : R_FAIL;
    end
    r = $urandom_range(0, 5);
    if (r == 0) return R_NONE;
    if (r < 3)  return R_BOTH;
    return R_FAIL;
  endfunction

  // Reference plan: expected writes, writer responses and final outcome.
  task automatic plan_run(input int mode, output bit exp_err, output logic [7:0] exp_idx);
    int          gap_extra, fails, attempts;
    bit          first;
    logic [15:0] w;
    exp_t        e;
    resp_t       r;
    gap_extra = 0;
    first     = 1'b1;
    exp_err   = 1'b0;
    exp_idx   = 8'd0;
    for (int i = 0; i < NUM; i++) begin
      w = TB_TABLE[i];
      if (w[15:8] == 8'hFF) begin
        gap_extra += (int'(w[7:0]) + 1) << DSHIFT;
      end else begin
        fails    = pick_fails(mode, i);
        attempts = (fails > MAXR) ? MAXR + 1 : fails + 1;
        for (int a = 0; a < attempts; a++) begin
          e.txn     = {DEV, w};
          e.min_gap = first ? 0 : SETTLE + 1 + ((a == 0) ? gap_extra : 0);
          first     = 1'b0;
          exp_q.push_back(e);
          r.kind  = (a < fails) ? pick_kind(mode, i, a) : R_DONE;
          r.delay = $urandom_range(1, 30);
          resp_q.push_back(r);
        end
        gap_extra = 0;
        if (fails > MAXR) begin
          exp_err = 1'b1;
          exp_idx = 8'(i);
          break;
        end
      end
    end
  endtask

  task automatic run_seq(input int mode);
    bit         exp_err;
    logic [7:0] exp_idx;
    int         n;
    plan_run(mode, exp_err, exp_idx);
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("busy_after_go", 32'(busy), 32'd1);
    check("no_start_in_load", 32'(wr_if.wr_start), 32'd0);
    @(negedge clk);
    check("start_latency", 32'(wr_if.wr_start), 32'd1);
    // go while busy must be ignored
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("busy_falls", 32'(n < 20000), 32'd1);
    repeat (SETTLE * 4) @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);
    check("init_done", 32'(init_done), 32'(!exp_err));
    check("init_error", 32'(init_error), 32'(exp_err));
    if (exp_err) check("error_index", 32'(error_index), 32'(exp_idx));
    check("writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    check("rst_error", 32'(init_error), 32'd0);
    check("rst_err_idx", 32'(error_index), 32'd0);
    check("rst_wr_start", 32'(wr_if.wr_start), 32'd0);
    check("rst_dev_addr", 32'(wr_if.wr_dev_address), 32'(DEV));
    check("rst_reg_data", 32'({wr_if.wr_reg_address, wr_if.wr_data}), 32'd0);
  endtask

  initial begin
    int n;
    bit         dummy_err;
    logic [7:0] dummy_idx;
    reset = 1'b1;
    go    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values();

    run_seq(0);
    run_seq(2);
    for (int k = 0; k < 12; k++) run_seq(1);

    // Reset while waiting on entry 1: everything aborts, no further starts.
    plan_run(0, dummy_err, dummy_idx);
    resp_q[1].delay = 20;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (exp_q.size() > 1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_entry1", 32'(n < 2000), 32'd1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    resp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values();
    repeat (60) @(negedge clk);
    check("quiet_after_reset", 32'(busy), 32'd0);

    run_seq(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
